// File: rtl/display_dither_pack_pkg.sv
// Shared types, Bayer threshold matrix and threshold scaling for the display dither stage.
// Pure declarations: no latency, no backpressure.
package display_pkg;

    typedef logic [1:0] pos_t;

    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    // Scale a 0..15 threshold so it spans one output LSB of a d-bit drop.
    function automatic logic [31:0] dither_add(input logic [3:0] b, input int d);
        logic [31:0] bw;
        bw = {28'd0, b};
        if (d >= 4)
            return bw << (d - 4);
        else if (d > 0)
            return bw >> (4 - d);
        else
            return '0;
    endfunction

endpackage

// File: rtl/display_dither_pack_if.sv
// Pixel bus: qualified RGB data plus raw DE/HSYNC/VSYNC timing, no backpressure.
// The producer drives through master, the consumer samples through slave.
interface display_dither_pack_if #(
    parameter int W = 12
);
    logic         valid;
    logic [W-1:0] data_r;
    logic [W-1:0] data_g;
    logic [W-1:0] data_b;
    logic         de;
    logic         hsync;
    logic         vsync;

    modport master (output valid, data_r, data_g, data_b, de, hsync, vsync);
    modport slave  (input  valid, data_r, data_g, data_b, de, hsync, vsync);
endinterface

// File: rtl/display_dither_pack_dither_chan.sv
// One colour channel: add threshold, saturate, truncate to OUT_WIDTH, register.
// One cycle of latency; holds its output whenever en is low, no backpressure.
module dither_chan
    import display_pkg::*;
#(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 pixel_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  in_dat,
    input  logic [IN_WIDTH-1:0]  add_dat,
    output logic [OUT_WIDTH-1:0] out_dat
);
    localparam int D = IN_WIDTH - OUT_WIDTH;

    logic [IN_WIDTH:0]    sum;
    logic [IN_WIDTH-1:0]  sat;
    logic [OUT_WIDTH-1:0] out_dat_d;
    logic [OUT_WIDTH-1:0] out_dat_q;

    always_comb begin
        sum       = {1'b0, in_dat} + {1'b0, add_dat};
        sat       = sum[IN_WIDTH] ? '1 : sum[IN_WIDTH-1:0];
        out_dat_d = en ? OUT_WIDTH'(sat >> D) : out_dat_q;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst)
            out_dat_q <= '0;
        else
            out_dat_q <= out_dat_d;
    end

    assign out_dat = out_dat_q;
endmodule

// File: rtl/display_dither_pack.sv
// 12->N bit RGB reduction with 4x4 ordered dither; 2-cycle latency on all outputs, no backpressure.
// DISPLAY_DITHER_TEMPORAL_EN adds a per-frame rotation of the dither matrix index.
module display_dither_pack
    import display_pkg::*;
#(
    parameter int   IN_WIDTH  = 12,
    parameter int   OUT_WIDTH = 8,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    display_dither_pack_if.slave  in_if,
    display_dither_pack_if.master out_if
);
    localparam int D = IN_WIDTH - OUT_WIDTH;

    pos_t x_q, x_d, y_q, y_d;
    pos_t idx_x, idx_y;
    logic de_prev_q, de_prev_d;
    logic vs_prev_q, vs_prev_d;
    logic vs_act, vs_edge, de_fall;
`ifdef DISPLAY_DITHER_TEMPORAL_EN
    pos_t f_q, f_d;
`endif

    logic [IN_WIDTH-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic [IN_WIDTH-1:0] add1_q, add1_d;
    // {valid, de, hsync, vsync} per stage
    logic [3:0] tim1_q, tim1_d, tim2_q, tim2_d;

    always_comb begin
        vs_act    = (in_if.vsync == VSYNC_POL);
        vs_edge   = vs_act && !vs_prev_q;
        de_fall   = de_prev_q && !in_if.de;
        de_prev_d = in_if.de;
        vs_prev_d = vs_act;

        x_d = !in_if.de ? pos_t'(0) : (in_if.valid ? x_q + 2'd1 : x_q);
        // A vsync edge restarts the frame even if a line ends in the same cycle.
        y_d = vs_edge ? pos_t'(0) : (de_fall ? y_q + 2'd1 : y_q);

`ifdef DISPLAY_DITHER_TEMPORAL_EN
        f_d   = vs_edge ? f_q + 2'd1 : f_q;
        idx_x = x_q + f_q;
        idx_y = y_q + f_q;
`else
        idx_x = x_q;
        idx_y = y_q;
`endif

        r1_d   = in_if.valid ? in_if.data_r : r1_q;
        g1_d   = in_if.valid ? in_if.data_g : g1_q;
        b1_d   = in_if.valid ? in_if.data_b : b1_q;
        add1_d = in_if.valid ? IN_WIDTH'(dither_add(BAYER4[idx_y][idx_x], D)) : add1_q;

        tim1_d = {in_if.valid, in_if.de, in_if.hsync, in_if.vsync};
        tim2_d = tim1_q;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
`ifdef DISPLAY_DITHER_TEMPORAL_EN
            f_q       <= '0;
`endif
            r1_q      <= '0;
            g1_q      <= '0;
            b1_q      <= '0;
            add1_q    <= '0;
            tim1_q    <= '0;
            tim2_q    <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            de_prev_q <= de_prev_d;
            vs_prev_q <= vs_prev_d;
`ifdef DISPLAY_DITHER_TEMPORAL_EN
            f_q       <= f_d;
`endif
            r1_q      <= r1_d;
            g1_q      <= g1_d;
            b1_q      <= b1_d;
            add1_q    <= add1_d;
            tim1_q    <= tim1_d;
            tim2_q    <= tim2_d;
        end
    end

    dither_chan #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_chan_r (
        .pixel_clk (pixel_clk), .rst (rst), .en (tim1_q[3]),
        .in_dat (r1_q), .add_dat (add1_q), .out_dat (out_if.data_r)
    );
    dither_chan #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_chan_g (
        .pixel_clk (pixel_clk), .rst (rst), .en (tim1_q[3]),
        .in_dat (g1_q), .add_dat (add1_q), .out_dat (out_if.data_g)
    );
    dither_chan #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_chan_b (
        .pixel_clk (pixel_clk), .rst (rst), .en (tim1_q[3]),
        .in_dat (b1_q), .add_dat (add1_q), .out_dat (out_if.data_b)
    );

    assign out_if.valid = tim2_q[3];
    assign out_if.de    = tim2_q[2];
    assign out_if.hsync = tim2_q[1];
    assign out_if.vsync = tim2_q[0];
endmodule

// File: tb/tb_display_dither_pack.sv
// Bench for display_dither_pack: 12->8 dither instance and a 12->12 passthrough instance
// share one input bus; hand-computed vectors plus a random run against a screen-position model.
module tb_display_dither_pack;

    logic pixel_clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 pixel_clk = ~pixel_clk;

    display_dither_pack_if #(.W(12)) in_if ();
    display_dither_pack_if #(.W(8))  out_if ();
    display_dither_pack_if #(.W(12)) out12_if ();

    display_dither_pack #(.IN_WIDTH(12), .OUT_WIDTH(8), .VSYNC_POL(1'b1)) dut (
        .pixel_clk (pixel_clk), .rst (rst), .in_if (in_if), .out_if (out_if)
    );
    display_dither_pack #(.IN_WIDTH(12), .OUT_WIDTH(12), .VSYNC_POL(1'b1)) dut_pt (
        .pixel_clk (pixel_clk), .rst (rst), .in_if (in_if), .out_if (out12_if)
    );

    // ---------------- reference model ----------------
    localparam int BAYER [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    typedef struct packed {
        logic v, de, hs, vs;
        logic [7:0]  r, g, b;
        logic [11:0] pr, pg, pb;
    } exp_t;

    exp_t cur = '0, m1 = '0, m2 = '0;
    int   col = 0, line = 0, frame = 0;
    bit   pde = 0, pvs = 0;

    function automatic logic [7:0] dith(input int v, input int thr);
        int s;
        s = v + thr;
        if (s > 4095) s = 4095;
        return 8'(s / 16);
    endfunction

    always @(posedge pixel_clk or posedge rst) begin
        int thr;
        if (rst) begin
            cur = '0; m1 = '0; m2 = '0;
            col = 0; line = 0; frame = 0; pde = 0; pvs = 0;
        end else begin
`ifdef DISPLAY_DITHER_TEMPORAL_EN
            thr = BAYER[(line + frame) % 4][(col + frame) % 4];
`else
            thr = BAYER[line][col];
`endif
            cur.v  = in_if.valid;
            cur.de = in_if.de;
            cur.hs = in_if.hsync;
            cur.vs = in_if.vsync;
            if (in_if.valid) begin
                cur.r  = dith(int'(in_if.data_r), thr);
                cur.g  = dith(int'(in_if.data_g), thr);
                cur.b  = dith(int'(in_if.data_b), thr);
                cur.pr = in_if.data_r;
                cur.pg = in_if.data_g;
                cur.pb = in_if.data_b;
            end
            m2 = m1;
            m1 = cur;
            if (!in_if.de) col = 0;
            else if (in_if.valid) col = (col + 1) % 4;
            if (in_if.vsync && !pvs) begin
                line  = 0;
                frame = (frame + 1) % 4;
            end else if (pde && !in_if.de) begin
                line = (line + 1) % 4;
            end
            pde = in_if.de;
            pvs = in_if.vsync;
        end
    end

    always @(negedge pixel_clk) begin
        vectors++;
        if ({out_if.valid, out_if.de, out_if.hsync, out_if.vsync, out_if.data_r, out_if.data_g, out_if.data_b}
            !== {m2.v, m2.de, m2.hs, m2.vs, m2.r, m2.g, m2.b}) begin
            miscompares++;
            $display("FAIL model8 t=%0t got v%b de%b hs%b vs%b %h %h %h want v%b de%b hs%b vs%b %h %h %h", $time,
                     out_if.valid, out_if.de, out_if.hsync, out_if.vsync, out_if.data_r, out_if.data_g, out_if.data_b,
                     m2.v, m2.de, m2.hs, m2.vs, m2.r, m2.g, m2.b);
        end
        vectors++;
        if ({out12_if.valid, out12_if.de, out12_if.hsync, out12_if.vsync, out12_if.data_r, out12_if.data_g, out12_if.data_b}
            !== {m2.v, m2.de, m2.hs, m2.vs, m2.pr, m2.pg, m2.pb}) begin
            miscompares++;
            $display("FAIL passthru t=%0t got v%b de%b hs%b vs%b %h %h %h want v%b de%b hs%b vs%b %h %h %h", $time,
                     out12_if.valid, out12_if.de, out12_if.hsync, out12_if.vsync, out12_if.data_r, out12_if.data_g,
                     out12_if.data_b, m2.v, m2.de, m2.hs, m2.vs, m2.pr, m2.pg, m2.pb);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [11:0] r, g, b, input logic v, de, hs, vs);
        @(posedge pixel_clk);
        #1;
        in_if.data_r = r;
        in_if.data_g = g;
        in_if.data_b = b;
        in_if.valid  = v;
        in_if.de     = de;
        in_if.hsync  = hs;
        in_if.vsync  = vs;
    endtask

    task automatic idle(input logic vs);
        drive(12'h0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0, vs);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] r, g, b;
        logic [7:0]  er, eg, eb;
    } vec_t;

    vec_t tbl[8];

    task automatic run_line(input int first, input int n);
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) drive(tbl[first+j].r, tbl[first+j].g, tbl[first+j].b, 1'b1, 1'b1, 1'b0, 1'b0);
            else       idle(1'b0);
            @(negedge pixel_clk);
            if (j >= 2) begin
                check($sformatf("tbl%0d_r", first + j - 2), 64'(out_if.data_r), 64'(tbl[first+j-2].er));
                check($sformatf("tbl%0d_g", first + j - 2), 64'(out_if.data_g), 64'(tbl[first+j-2].eg));
                check($sformatf("tbl%0d_b", first + j - 2), 64'(out_if.data_b), 64'(tbl[first+j-2].eb));
            end
        end
    endtask

    task automatic filler(input int n);
        for (int j = 0; j < n; j++)
            drive(12'($urandom), 12'($urandom), 12'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
    endtask

    logic [7:0] texp[4];

    initial begin
        // x sequence 0,1,2,3,0,1 on line y=0, then x0/x1 on line y=3
        tbl[0] = '{12'h7F8, 12'hFFF, 12'h00F, 8'h7F, 8'hFF, 8'h00};
        tbl[1] = '{12'h7F8, 12'hFFF, 12'h00F, 8'h80, 8'hFF, 8'h01};
        tbl[2] = '{12'h7F8, 12'hFFF, 12'h00F, 8'h7F, 8'hFF, 8'h01};
        tbl[3] = '{12'h7F8, 12'hFFF, 12'h00F, 8'h80, 8'hFF, 8'h01};
        tbl[4] = '{12'h7F8, 12'hFFF, 12'h00F, 8'h7F, 8'hFF, 8'h00};
        tbl[5] = '{12'h7F8, 12'hFFF, 12'h00F, 8'h80, 8'hFF, 8'h01};
        tbl[6] = '{12'hFFF, 12'hFF0, 12'h7F8, 8'hFF, 8'hFF, 8'h80};
        tbl[7] = '{12'hFFF, 12'hFF0, 12'h7F8, 8'hFF, 8'hFF, 8'h7F};
`ifdef DISPLAY_DITHER_TEMPORAL_EN
        texp = '{8'h7F, 8'h80, 8'h7F, 8'h80};
`else
        texp = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
`endif

        in_if.valid = 0; in_if.de = 0; in_if.hsync = 0; in_if.vsync = 0;
        in_if.data_r = 0; in_if.data_g = 0; in_if.data_b = 0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check("reset_out8", 64'({out_if.valid, out_if.de, out_if.hsync, out_if.vsync,
                                 out_if.data_r, out_if.data_g, out_if.data_b}), 64'd0);
        check("reset_out12", 64'({out12_if.valid, out12_if.de, out12_if.hsync, out12_if.vsync,
                                  out12_if.data_r, out12_if.data_g, out12_if.data_b}), 64'd0);
        rst = 1'b0;
        idle(1'b0);
        idle(1'b0);

        // dither rounding, x wrap, y advancing on de falls, saturation at y=3
        run_line(0, 6);
        filler(3);
        filler(3);
        run_line(6, 2);

        // vsync edge in the same cycle de falls: next line must be y=0, not y=1
        for (int j = 0; j < 3; j++) drive(12'h123, 12'h456, 12'h789, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        drive(12'h7F8, 12'h7F8, 12'h7F8, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        @(negedge pixel_clk);
        check("vs_de_same_cycle", 64'(out_if.data_r), 64'h7F);
        idle(1'b0);

        // asynchronous reset mid-line
        for (int j = 0; j < 3; j++) drive(12'h7F8, 12'h7F8, 12'h7F8, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge pixel_clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out8", 64'({out_if.valid, out_if.de, out_if.hsync, out_if.vsync,
                                   out_if.data_r, out_if.data_g, out_if.data_b}), 64'd0);
        check("rst_mid_out12", 64'({out12_if.valid, out12_if.de, out12_if.hsync, out12_if.vsync,
                                    out12_if.data_r, out12_if.data_g, out12_if.data_b}), 64'd0);
        @(posedge pixel_clk);
        #1;
        rst = 1'b0;
        @(posedge pixel_clk);
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        check("post_rst_x0", 64'(out_if.data_r), 64'h7F);
        @(negedge pixel_clk);
        check("post_rst_x1", 64'(out_if.data_r), 64'h80);
        idle(1'b0);

        // one pixel at (x0, y0) in each of four frames
        @(posedge pixel_clk);
        #1;
        rst = 1'b1;
        @(posedge pixel_clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(12'h7FC, 12'h7FC, 12'h7FC, 1'b1, 1'b1, 1'b0, 1'b0);
            idle(1'b0);
            idle(1'b0);
            @(negedge pixel_clk);
            check($sformatf("frame%0d_r", k), 64'(out_if.data_r), 64'(texp[k]));
            idle(1'b1);
            idle(1'b0);
        end

        // random lines with gaps, invalid pixels and occasional vsync pulses
        for (int l = 0; l < 200; l++) begin
            int  len, gap;
            bit  vsp;
            len = $urandom_range(1, 9);
            gap = $urandom_range(1, 4);
            vsp = ($urandom_range(0, 5) == 0);
            for (int j = 0; j < len; j++)
                drive(12'($urandom), 12'($urandom), 12'($urandom),
                      1'($urandom_range(0, 3) != 0), 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < gap + (vsp ? 2 : 0); j++)
                drive(12'($urandom), 12'($urandom), 12'($urandom),
                      1'($urandom_range(0, 1)), 1'b0, 1'(j == 0), 1'(vsp && j < 2));
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        @(negedge pixel_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
